// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - Wishbone instruction prefetch queue feeding a dual-issue buffer.
// Optional FETCH_QUEUE_ERR_EN adds the sticky consume_err output.
module fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [31:0] instruction0,
    output logic [31:0] instruction1,
    output logic        valid0,
    output logic        valid1,
    output logic [31:0] pc0,
    input  logic [1:0]  consume,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_QUEUE_ERR_EN
    ,
    output logic        consume_err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        drain_adr_q, drain_adr_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        pc0_q, pc0_d;
    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        mem_d [DEPTH];

    logic [31:0]        redirect_pc_al;
    logic [1:0]         cons_clip;
    logic [CNT_W-1:0]   cons_ext;
    logic [CNT_W-1:0]   eff_cons;
    logic               ack_take;
    logic [PTR_W-1:0]   head_next1;

    always_comb begin
        redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;
        cons_clip      = (consume == 2'd3) ? 2'd2 : consume;
        cons_ext       = CNT_W'(cons_clip);
        // Only words already queued can retire; an arriving word waits a cycle.
        eff_cons       = (cons_ext > count_q) ? count_q : cons_ext;
        ack_take       = (state_q == ST_REQ) && wb_ack_i && !redirect;
        head_next1     = head_q + PTR_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drain_adr_d = drain_adr_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    state_d    = ST_REQ;
                    fetch_pc_d = redirect_pc_al;
                end else if (count_q < CNT_W'(DEPTH)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                    if (wb_ack_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Keep the bus address stable until the stale ack returns.
                        state_d     = ST_DRAIN;
                        drain_adr_d = fetch_pc_q;
                    end
                end else if (wb_ack_i) begin
                    state_d    = ST_IDLE;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                end
                if (wb_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc0_d   = pc0_q;
        mem_d   = mem_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc0_d   = redirect_pc_al;
        end else begin
            head_d  = head_q + PTR_W'(eff_cons);
            count_d = count_q + CNT_W'(ack_take) - eff_cons;
            pc0_d   = pc0_q + (32'(eff_cons) << 2);
            if (ack_take) begin
                mem_d[tail_q] = wb_dat_i;
                tail_d        = tail_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            drain_adr_q <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            pc0_q       <= RESET_PC;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drain_adr_q <= drain_adr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            pc0_q       <= pc0_d;
            mem_q       <= mem_d;
        end
    end

`ifdef FETCH_QUEUE_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((consume == 2'd3) || (CNT_W'(consume) > count_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign consume_err = err_q;
`endif

    assign wb_cyc_o     = (state_q != ST_IDLE);
    assign wb_stb_o     = (state_q != ST_IDLE);
    assign wb_adr_o     = (state_q == ST_DRAIN) ? drain_adr_q : fetch_pc_q;
    assign valid0       = (count_q != '0);
    assign valid1       = (count_q > CNT_W'(1));
    assign instruction0 = valid0 ? mem_q[head_q] : 32'd0;
    assign instruction1 = valid1 ? mem_q[head_next1] : 32'd0;
    assign pc0          = pc0_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized bench for fetch_queue against a transaction-level queue model.
module tb_fetch_queue;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        wb_cyc_o, wb_stb_o, wb_ack_i;
    logic [31:0] wb_adr_o, wb_dat_i;
    logic [31:0] instruction0, instruction1, pc0, redirect_pc;
    logic        valid0, valid1, redirect;
    logic [1:0]  consume;
`ifdef FETCH_QUEUE_ERR_EN
    logic        consume_err;
    bit          m_err;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .instruction0 (instruction0),
        .instruction1 (instruction1),
        .valid0       (valid0),
        .valid1       (valid1),
        .pc0          (pc0),
        .consume      (consume),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
`ifdef FETCH_QUEUE_ERR_EN
        ,
        .consume_err  (consume_err)
`endif
    );

    always #5 clk = ~clk;

    // Model: queued words, pc of the oldest, address of the next useful fetch,
    // and whether the outstanding bus cycle belongs to a flushed stream.
    logic [31:0] m_q[$];
    logic [31:0] m_pc0, m_next, m_stale_addr;
    bit          m_stale, prev_ack, prev_redir_idle, rand_lat;
    int          lat, wcnt, idle_run;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    function automatic bit will_ack();
        return wb_stb_o && (wcnt + 1 >= lat);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc0           = RESET_PC;
        m_next          = RESET_PC;
        m_stale_addr    = RESET_PC;
        m_stale         = 1'b0;
        prev_ack        = 1'b0;
        prev_redir_idle = 1'b0;
        idle_run        = 0;
        wcnt            = 0;
`ifdef FETCH_QUEUE_ERR_EN
        m_err           = 1'b0;
`endif
    endtask

    // Called just after a falling edge: check, drive inputs, advance model, wait one cycle.
    task automatic tick(input logic [1:0] cons, input logic redir, input logic [31:0] rpc,
                        input bit force_ack);
        int          sz, cc, eff;
        bit          ack, stb;
        logic [31:0] al;
        sz  = m_q.size();
        stb = wb_stb_o;
        chk("cyc_eq_stb", wb_cyc_o, wb_stb_o);
        chk("valid0", valid0, sz >= 1);
        chk("valid1", valid1, sz >= 2);
        if (sz >= 1) chk("instr0", instruction0, m_q[0]);
        else         chk("instr0_zero", instruction0, 32'd0);
        if (sz >= 2) chk("instr1", instruction1, m_q[1]);
        else         chk("instr1_zero", instruction1, 32'd0);
        chk("pc0", pc0, m_pc0);
        if (stb) chk("bus_adr", wb_adr_o, m_stale ? m_stale_addr : m_next);
        if (sz == DEPTH) chk("full_no_req", wb_stb_o, 1'b0);
        if (prev_ack) chk("stb_drop_after_ack", wb_stb_o, 1'b0);
        if (prev_redir_idle) chk("redirect_req_latency", wb_stb_o, 1'b1);
        if (!stb && sz < DEPTH) idle_run++;
        else                    idle_run = 0;
        if (idle_run > 2) chk("fetch_stalled", idle_run, 2);
`ifdef FETCH_QUEUE_ERR_EN
        chk("consume_err", consume_err, m_err);
`endif

        if (stb) begin
            wcnt++;
            ack = (wcnt >= lat);
        end else begin
            wcnt = 0;
            ack  = 1'b0;
        end
        if (ack) begin
            wcnt = 0;
            if (rand_lat) lat = $urandom_range(1, 4);
        end
        if (force_ack) ack = 1'b1;

        consume     = cons;
        redirect    = redir;
        redirect_pc = rpc;
        wb_ack_i    = ack;
        wb_dat_i    = ack ? mem_word(wb_adr_o) : $urandom;

        cc  = (cons == 2'd3) ? 2 : int'(cons);
        eff = (cc < sz) ? cc : sz;
`ifdef FETCH_QUEUE_ERR_EN
        if (cons == 2'd3 || int'(cons) > sz) m_err = 1'b1;
`endif
        al = rpc & 32'hFFFF_FFFC;
        if (redir) begin
            if (stb && !ack) begin
                if (!m_stale) m_stale_addr = m_next;
                m_stale = 1'b1;
            end else if (stb && ack) begin
                m_stale = 1'b0;
            end
            m_q.delete();
            m_pc0  = al;
            m_next = al;
        end else begin
            repeat (eff) void'(m_q.pop_front());
            m_pc0 = m_pc0 + 32'(4 * eff);
            if (stb && ack) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    m_q.push_back(mem_word(m_next));
                    m_next = m_next + 32'd4;
                end
            end
        end
        prev_ack        = ack && stb;
        prev_redir_idle = redir && !stb;
        @(negedge clk);
    endtask

    initial begin
        n_rst       = 1'b0;
        consume     = 2'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        wb_ack_i    = 1'b0;
        wb_dat_i    = 32'd0;
        lat         = 3;
        rand_lat    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_adr", wb_adr_o, RESET_PC);
        chk("rst_valid", {valid1, valid0}, 2'b00);
        chk("rst_instr0", instruction0, 32'd0);
        chk("rst_pc0", pc0, RESET_PC);
        n_rst = 1'b1;

        // Fill with 3-cycle acks and no consumption.
        repeat (60) tick(2'd0, 1'b0, 32'd0, 1'b0);
        chk("fill_stb", wb_stb_o, 1'b0);
        chk("fill_valid", {valid1, valid0}, 2'b11);
        chk("fill_i0", instruction0, 32'd1);
        chk("fill_i1", instruction1, 32'd2);
        chk("fill_pc0", pc0, 32'd0);

        // Drain two per cycle from full across the pointer wrap.
        lat = 1;
        repeat (40) tick(2'd2, 1'b0, 32'd0, 1'b0);
        repeat (30) tick(2'd0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 60; i++) tick((i % 2) ? 2'd1 : 2'd0, 1'b0, 32'd0, 1'b0);

        // Redirect while a request is outstanding; stale ack arrives two cycles later.
        lat = 3;
        for (int k = 0; k < 20 && !(wb_stb_o && wcnt == 0); k++) tick(2'd1, 1'b0, 32'd0, 1'b0);
        chk("wait_req", wb_stb_o, 1'b1);
        tick(2'd0, 1'b1, 32'h0000_0103, 1'b0);
        chk("redir_valid0", valid0, 1'b0);
        chk("redir_pc0", pc0, 32'h0000_0100);
        for (int k = 0; k < 20 && !valid0; k++) tick(2'd0, 1'b0, 32'd0, 1'b0);
        chk("redir_first_i0", instruction0, mem_word(32'h0000_0100));
        chk("redir_first_pc0", pc0, 32'h0000_0100);

        // One word queued, consume of two clips to one.
        lat = 2;
        tick(2'd0, 1'b1, 32'h0000_0200, 1'b0);
        for (int k = 0; k < 20 && !valid0; k++) tick(2'd0, 1'b0, 32'd0, 1'b0);
        chk("one_word", {valid1, valid0}, 2'b01);
        tick(2'd2, 1'b0, 32'd0, 1'b0);
        chk("single_valid0", valid0, 1'b0);
        chk("single_pc0", pc0, 32'h0000_0204);
`ifdef FETCH_QUEUE_ERR_EN
        chk("err_set", consume_err, 1'b1);
        repeat (5) tick(2'd0, 1'b0, 32'd0, 1'b0);
        chk("err_sticky", consume_err, 1'b1);
`endif

        // Redirect coinciding with an ack.
        for (int k = 0; k < 20 && !will_ack(); k++) tick(2'd0, 1'b0, 32'd0, 1'b0);
        chk("wait_ack", wb_stb_o, 1'b1);
        tick(2'd0, 1'b1, 32'h0000_0300, 1'b0);
        for (int k = 0; k < 20 && !valid0; k++) tick(2'd0, 1'b0, 32'd0, 1'b0);
        chk("redir_ack_i0", instruction0, mem_word(32'h0000_0300));
        chk("redir_ack_pc0", pc0, 32'h0000_0300);

        // Address and pc0 wrap through 2^32.
        lat = 1;
        tick(2'd0, 1'b1, 32'hFFFF_FFF6, 1'b0);
        repeat (30) tick(2'd0, 1'b0, 32'd0, 1'b0);
        repeat (20) tick(2'd1, 1'b0, 32'd0, 1'b0);

        // Randomized traffic.
        rand_lat = 1'b1;
        repeat (1500) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                              : $urandom;
            tick(2'($urandom_range(0, 3)), $urandom_range(0, 99) < 3, rpc, 1'b0);
        end

        // Asynchronous reset in the middle of a bus cycle, then a late ack.
        for (int k = 0; k < 20 && !wb_stb_o; k++) tick(2'd0, 1'b0, 32'd0, 1'b0);
        chk("wait_req_rst", wb_stb_o, 1'b1);
        wb_ack_i = 1'b0;
        redirect = 1'b0;
        consume  = 2'd0;
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_stb", wb_stb_o, 1'b0);
        chk("midrst_cyc", wb_cyc_o, 1'b0);
        chk("midrst_adr", wb_adr_o, RESET_PC);
        chk("midrst_pc0", pc0, RESET_PC);
        @(negedge clk);
        model_reset();
        lat   = 2;
        n_rst = 1'b1;
        tick(2'd0, 1'b0, 32'd0, 1'b1);
        repeat (300) begin
            tick(2'($urandom_range(0, 3)), $urandom_range(0, 99) < 4, $urandom, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
